// File: rtl/tick_latency_monitor.sv
// Tick latency monitor: re-presents timer ticks as an interrupt, measures tick-to-ack latency and counts overruns.
// Optional max-latency tracking is built only when TICK_LATENCY_MAX_EN is defined.
module tick_latency_monitor #(
    parameter int LAT_W = 16,
    parameter int OVR_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_in,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [2:0]  address,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        irq
);

    localparam logic [LAT_W-1:0] LAT_SAT = '1;
    localparam logic [OVR_W-1:0] OVR_SAT = '1;

    logic             r_tickD;
    logic             r_pending;
    logic             r_overrun;
    logic             r_irqEn;
    logic             r_monEn;
    logic [LAT_W-1:0] r_lat;
    logic [LAT_W-1:0] r_lastLat;
    logic [OVR_W-1:0] r_ovrCnt;
    logic [15:0]      r_tickCnt;
    logic [15:0]      r_readdata;

    logic             w_write;
    logic             w_edge;
    logic             w_ack;
    logic             w_overrun;
    logic             w_clrStatus;
    logic             w_clrMax;
    logic             w_clrOvr;
    logic             w_ctrlWr;
    logic [15:0]      w_maxRead;
    logic [15:0]      w_readMux;
    logic             w_unusedBits;

    assign w_write     = chipselect & ~write_n;
    assign w_edge      = tick_in & ~r_tickD & r_monEn;
    assign w_ack       = w_write & (address == 3'd2) & r_pending;
    // An ack in the same cycle as an edge retires the old tick, so it is not an overrun.
    assign w_overrun   = w_edge & r_pending & ~w_ack;
    assign w_clrStatus = w_write & (address == 3'd0) & writedata[1];
    assign w_ctrlWr    = w_write & (address == 3'd1);
    assign w_clrMax    = w_write & (address == 3'd4);
    assign w_clrOvr    = w_write & (address == 3'd5);
    assign w_unusedBits = ^writedata[15:2];

    assign irq      = r_pending & r_irqEn;
    assign readdata = r_readdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tickD   <= 1'b0;
            r_pending <= 1'b0;
            r_lat     <= '0;
            r_lastLat <= '0;
        end else begin
            r_tickD <= tick_in;
            if (w_edge) begin
                r_pending <= 1'b1;
            end else if (w_ack) begin
                r_pending <= 1'b0;
            end
            // On overrun the counter keeps running so latency reflects the oldest unacked tick.
            if (w_edge && !w_overrun) begin
                r_lat <= '0;
            end else if (r_pending && (r_lat != LAT_SAT)) begin
                r_lat <= r_lat + 1'b1;
            end
            if (w_ack) begin
                r_lastLat <= r_lat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overrun <= 1'b0;
            r_ovrCnt  <= '0;
            r_tickCnt <= '0;
            r_irqEn   <= 1'b0;
            r_monEn   <= 1'b0;
        end else begin
            if (w_overrun) begin
                r_overrun <= 1'b1;
            end else if (w_clrStatus) begin
                r_overrun <= 1'b0;
            end
            if (w_clrOvr) begin
                r_ovrCnt <= '0;
            end else if (w_overrun && (r_ovrCnt != OVR_SAT)) begin
                r_ovrCnt <= r_ovrCnt + 1'b1;
            end
            if (w_edge) begin
                r_tickCnt <= r_tickCnt + 16'd1;
            end
            if (w_ctrlWr) begin
                r_irqEn <= writedata[0];
                r_monEn <= writedata[1];
            end
        end
    end

`ifdef TICK_LATENCY_MAX_EN
    logic [LAT_W-1:0] r_maxLat;

    // A clear coinciding with a capture keeps the captured value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_maxLat <= '0;
        end else if (w_ack && (w_clrMax || (r_lat > r_maxLat))) begin
            r_maxLat <= r_lat;
        end else if (w_clrMax) begin
            r_maxLat <= '0;
        end
    end

    assign w_maxRead = 16'(r_maxLat);
`else
    assign w_maxRead = 16'd0;
`endif

    always_comb begin
        w_readMux = 16'd0;
        case (address)
            3'd0:    w_readMux = {14'd0, r_overrun, r_pending};
            3'd1:    w_readMux = {14'd0, r_monEn, r_irqEn};
            3'd3:    w_readMux = 16'(r_lastLat);
            3'd4:    w_readMux = w_maxRead;
            3'd5:    w_readMux = 16'(r_ovrCnt);
            3'd6:    w_readMux = r_tickCnt;
            default: w_readMux = 16'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_readdata <= 16'd0;
        end else begin
            r_readdata <= w_readMux;
        end
    end

endmodule

// File: tb/tb_tick_latency_monitor.sv
// Testbench for tick_latency_monitor: two instances (LAT_W=16/OVR_W=16 and LAT_W=4/OVR_W=2) share all inputs
// and are checked against a timestamp-based reference model; TICK_LATENCY_MAX_EN selects the MAX_LAT expectation.
module tb_tick_latency_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick_in;
    logic        chipselect;
    logic        write_n;
    logic [2:0]  address;
    logic [15:0] writedata;
    logic [15:0] rdA;
    logic [15:0] rdB;
    logic        irqA;
    logic        irqB;

    int testsRun = 0;
    int testsFailed = 0;

`ifdef TICK_LATENCY_MAX_EN
    localparam bit MAX_EN = 1'b1;
`else
    localparam bit MAX_EN = 1'b0;
`endif

    tick_latency_monitor dutA (
        .clk(clk), .reset(reset), .tick_in(tick_in), .chipselect(chipselect), .write_n(write_n),
        .address(address), .writedata(writedata), .readdata(rdA), .irq(irqA)
    );

    tick_latency_monitor #(.LAT_W(4), .OVR_W(2)) dutB (
        .clk(clk), .reset(reset), .tick_in(tick_in), .chipselect(chipselect), .write_n(write_n),
        .address(address), .writedata(writedata), .readdata(rdB), .irq(irqB)
    );

    always #5 clk = ~clk;

    // Reference model: latency is the distance between the tick cycle and the ack cycle, clipped to the width.
    int latSat[2] = '{65535, 15};
    int ovrSat[2] = '{65535, 3};
    bit mPending[2];
    bit mOverrun[2];
    int mTickCycle[2];
    int mLastLat[2];
    int mMaxLat[2];
    int mOvrCnt[2];
    int mTickCnt = 0;
    bit mIrqEn = 1'b0;
    bit mMonEn = 1'b0;
    bit mTickPrev = 1'b0;
    int mCyc = 0;

    task automatic modelStep();
        bit wr, edgeSeen, ack, ovr;
        int lat;
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                mPending[i] = 1'b0; mOverrun[i] = 1'b0; mLastLat[i] = 0;
                mMaxLat[i] = 0; mOvrCnt[i] = 0; mTickCycle[i] = 0;
            end
            mTickCnt = 0; mIrqEn = 1'b0; mMonEn = 1'b0; mTickPrev = 1'b0;
        end else begin
            wr = chipselect && !write_n;
            edgeSeen = tick_in && !mTickPrev && mMonEn;
            for (int i = 0; i < 2; i++) begin
                ack = wr && (address == 3'd2) && mPending[i];
                lat = mCyc - mTickCycle[i] - 1;
                if (lat > latSat[i]) lat = latSat[i];
                ovr = edgeSeen && mPending[i] && !ack;
                if (ack) mLastLat[i] = lat;
                if (wr && address == 3'd4) mMaxLat[i] = ack ? lat : 0;
                else if (ack && lat > mMaxLat[i]) mMaxLat[i] = lat;
                if (wr && address == 3'd5) mOvrCnt[i] = 0;
                else if (ovr && mOvrCnt[i] < ovrSat[i]) mOvrCnt[i] = mOvrCnt[i] + 1;
                mOverrun[i] = ovr || (mOverrun[i] && !(wr && address == 3'd0 && writedata[1]));
                if (edgeSeen && !ovr) mTickCycle[i] = mCyc;
                if (edgeSeen) mPending[i] = 1'b1;
                else if (ack) mPending[i] = 1'b0;
            end
            if (edgeSeen) mTickCnt = (mTickCnt + 1) % 65536;
            if (wr && address == 3'd1) begin
                mIrqEn = writedata[0];
                mMonEn = writedata[1];
            end
            mTickPrev = tick_in;
        end
        mCyc = mCyc + 1;
    endtask

    always @(posedge clk) modelStep();

    function automatic logic [15:0] expRead(input int i, input logic [2:0] a);
        case (a)
            3'd0: return {14'd0, mOverrun[i], mPending[i]};
            3'd1: return {14'd0, mMonEn, mIrqEn};
            3'd3: return 16'(mLastLat[i]);
            3'd4: return MAX_EN ? 16'(mMaxLat[i]) : 16'd0;
            3'd5: return 16'(mOvrCnt[i]);
            3'd6: return 16'(mTickCnt);
            default: return 16'd0;
        endcase
    endfunction

    // Every stimulus task starts at a falling edge, occupies that cycle, and returns at the next falling edge.
    task automatic busWrite(input logic [2:0] a, input logic [15:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; writedata = 16'd0;
    endtask

    task automatic busRead(input logic [2:0] a, output logic [15:0] gA, output logic [15:0] gB);
        address = a;
        @(negedge clk);
        gA = rdA; gB = rdB;
    endtask

    task automatic pulseTick();
        tick_in = 1'b1;
        @(negedge clk);
        tick_in = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [15:0] gA, gB;
        reset = 1'b1;
        waitCycles(3);
        reset = 1'b0;
        for (int a = 0; a < 8; a++) begin
            busRead(3'(a), gA, gB);
            testsRun++;
            if (gA !== 16'd0 || gB !== 16'd0) begin
                testsFailed++;
                $display("[TB] FAIL reset_read addr %0d: got %h/%h expected 0000/0000", a, gA, gB);
            end
        end
        testsRun++;
        if (irqA !== 1'b0 || irqB !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_irq: got %b/%b expected 0/0", irqA, irqB);
        end
    endtask

    task automatic test_single_tick();
        logic [15:0] gA, gB;
        busWrite(3'd1, 16'h0003);
        pulseTick();
        for (int k = 0; k <= 10; k++) begin
            testsRun++;
            if (irqA !== 1'b1 || irqB !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL irq_high cycle %0d after tick: got %b/%b expected 1/1", k + 1, irqA, irqB);
            end
            if (k < 10) @(negedge clk);
        end
        busWrite(3'd2, 16'h0000);
        testsRun++;
        if (irqA !== 1'b0 || irqB !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL irq_after_ack: got %b/%b expected 0/0", irqA, irqB);
        end
        busRead(3'd3, gA, gB);
        testsRun++;
        if (gA !== 16'd10 || gB !== 16'd10) begin
            testsFailed++;
            $display("[TB] FAIL single_last_lat: got %0d/%0d expected 10/10", gA, gB);
        end
        busRead(3'd4, gA, gB);
        testsRun++;
        if (gA !== (MAX_EN ? 16'd10 : 16'd0) || gB !== (MAX_EN ? 16'd10 : 16'd0)) begin
            testsFailed++;
            $display("[TB] FAIL single_max_lat: got %0d/%0d expected %0d", gA, gB, MAX_EN ? 10 : 0);
        end
        busRead(3'd6, gA, gB);
        testsRun++;
        if (gA !== 16'd1 || gB !== 16'd1) begin
            testsFailed++;
            $display("[TB] FAIL single_tick_cnt: got %0d/%0d expected 1/1", gA, gB);
        end
    endtask

    task automatic test_overrun();
        logic [15:0] gA, gB;
        pulseTick();
        waitCycles(49);
        pulseTick();
        busRead(3'd5, gA, gB);
        testsRun++;
        if (gA !== 16'd1 || gB !== 16'd1) begin
            testsFailed++;
            $display("[TB] FAIL overrun_cnt: got %0d/%0d expected 1/1", gA, gB);
        end
        busRead(3'd0, gA, gB);
        testsRun++;
        if (gA !== 16'h0003 || gB !== 16'h0003) begin
            testsFailed++;
            $display("[TB] FAIL overrun_status: got %h/%h expected 0003/0003", gA, gB);
        end
        waitCycles(2);
        busWrite(3'd2, 16'h0000);
        busRead(3'd3, gA, gB);
        testsRun++;
        if (gA !== 16'd54 || gB !== 16'd15) begin
            testsFailed++;
            $display("[TB] FAIL overrun_last_lat: got %0d/%0d expected 54/15", gA, gB);
        end
        busWrite(3'd0, 16'h0002);
        busRead(3'd0, gA, gB);
        testsRun++;
        if (gA !== 16'h0000 || gB !== 16'h0000) begin
            testsFailed++;
            $display("[TB] FAIL status_clear: got %h/%h expected 0000/0000", gA, gB);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] gA, gB;
        pulseTick();
        waitCycles(3);
        tick_in = 1'b1; chipselect = 1'b1; write_n = 1'b0; address = 3'd2;
        @(negedge clk);
        tick_in = 1'b0; chipselect = 1'b0; write_n = 1'b1;
        testsRun++;
        if (irqA !== 1'b1 || irqB !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL simul_pending: got %b/%b expected 1/1", irqA, irqB);
        end
        busRead(3'd5, gA, gB);
        testsRun++;
        if (gA !== 16'd1 || gB !== 16'd1) begin
            testsFailed++;
            $display("[TB] FAIL simul_ovr_cnt: got %0d/%0d expected 1/1", gA, gB);
        end
        waitCycles(1);
        busWrite(3'd2, 16'h0000);
        busRead(3'd3, gA, gB);
        testsRun++;
        if (gA !== 16'd2 || gB !== 16'd2) begin
            testsFailed++;
            $display("[TB] FAIL simul_last_lat: got %0d/%0d expected 2/2", gA, gB);
        end
    endtask

    task automatic test_saturation();
        logic [15:0] gA, gB;
        pulseTick();
        waitCycles(39);
        busWrite(3'd2, 16'h0000);
        busRead(3'd3, gA, gB);
        testsRun++;
        if (gA !== 16'd39 || gB !== 16'd15) begin
            testsFailed++;
            $display("[TB] FAIL sat_last_lat: got %0d/%0d expected 39/15", gA, gB);
        end
        busWrite(3'd2, 16'h0000);
        busRead(3'd3, gA, gB);
        testsRun++;
        if (gA !== 16'd39 || gB !== 16'd15) begin
            testsFailed++;
            $display("[TB] FAIL idle_ack_last_lat: got %0d/%0d expected 39/15", gA, gB);
        end
        busRead(3'd4, gA, gB);
        testsRun++;
        if (gA !== (MAX_EN ? 16'd54 : 16'd0) || gB !== (MAX_EN ? 16'd15 : 16'd0)) begin
            testsFailed++;
            $display("[TB] FAIL sat_max_lat: got %0d/%0d expected %0d/%0d", gA, gB,
                     MAX_EN ? 54 : 0, MAX_EN ? 15 : 0);
        end
        busWrite(3'd4, 16'h0000);
        busRead(3'd4, gA, gB);
        testsRun++;
        if (gA !== 16'd0 || gB !== 16'd0) begin
            testsFailed++;
            $display("[TB] FAIL max_clear: got %0d/%0d expected 0/0", gA, gB);
        end
    endtask

    task automatic test_ovr_saturation();
        logic [15:0] gA, gB;
        busWrite(3'd5, 16'h0000);
        pulseTick();
        repeat (4) begin
            waitCycles(1);
            pulseTick();
        end
        busRead(3'd5, gA, gB);
        testsRun++;
        if (gA !== 16'd4 || gB !== 16'd3) begin
            testsFailed++;
            $display("[TB] FAIL ovr_saturate: got %0d/%0d expected 4/3", gA, gB);
        end
        busWrite(3'd2, 16'h0000);
        busWrite(3'd0, 16'h0002);
        busWrite(3'd5, 16'h0000);
    endtask

    task automatic test_mon_disable();
        logic [15:0] gA, gB;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        busWrite(3'd1, 16'h0001);
        repeat (5) begin
            pulseTick();
            waitCycles(1);
        end
        testsRun++;
        if (irqA !== 1'b0 || irqB !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL mon_off_irq: got %b/%b expected 0/0", irqA, irqB);
        end
        busRead(3'd6, gA, gB);
        testsRun++;
        if (gA !== 16'd0 || gB !== 16'd0) begin
            testsFailed++;
            $display("[TB] FAIL mon_off_tick_cnt: got %0d/%0d expected 0/0", gA, gB);
        end
        busWrite(3'd1, 16'h0003);
        pulseTick();
        busWrite(3'd1, 16'h0001);
        waitCycles(3);
        testsRun++;
        if (irqA !== 1'b1 || irqB !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL mon_off_pending_kept: got %b/%b expected 1/1", irqA, irqB);
        end
        busWrite(3'd2, 16'h0000);
        busRead(3'd3, gA, gB);
        testsRun++;
        if (gA !== 16'd4 || gB !== 16'd4) begin
            testsFailed++;
            $display("[TB] FAIL mon_off_ack_lat: got %0d/%0d expected 4/4", gA, gB);
        end
        busWrite(3'd1, 16'h0003);
        pulseTick();
        reset = 1'b1;
        @(negedge clk);
        testsRun++;
        if (irqA !== 1'b0 || irqB !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_mid_irq: got %b/%b expected 0/0", irqA, irqB);
        end
        reset = 1'b0;
        for (int a = 0; a < 8; a++) begin
            busRead(3'(a), gA, gB);
            testsRun++;
            if (gA !== 16'd0 || gB !== 16'd0) begin
                testsFailed++;
                $display("[TB] FAIL reset_mid_read addr %0d: got %h/%h expected 0000/0000", a, gA, gB);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] eA, eB;
        bit haveExp;
        int r;
        haveExp = 1'b0;
        eA = 16'd0;
        eB = 16'd0;
        busWrite(3'd1, 16'h0003);
        for (int n = 0; n < 1500; n++) begin
            if (haveExp) begin
                testsRun++;
                if (rdA !== eA || rdB !== eB) begin
                    testsFailed++;
                    $display("[TB] FAIL random_read cycle %0d: got %h/%h expected %h/%h", n, rdA, rdB, eA, eB);
                end
            end
            testsRun++;
            if (irqA !== (mPending[0] & mIrqEn) || irqB !== (mPending[1] & mIrqEn)) begin
                testsFailed++;
                $display("[TB] FAIL random_irq cycle %0d: got %b/%b expected %b/%b", n, irqA, irqB,
                         mPending[0] & mIrqEn, mPending[1] & mIrqEn);
            end
            if ($urandom_range(0, 99) < 15) tick_in = ~tick_in;
            chipselect = 1'b0;
            write_n = 1'b1;
            writedata = 16'($urandom);
            address = 3'($urandom_range(0, 7));
            r = $urandom_range(0, 99);
            if (r < 10) begin
                chipselect = 1'b1; write_n = 1'b0; address = 3'd2;
            end else if (r < 12) begin
                chipselect = 1'b1; write_n = 1'b0; address = 3'd1;
                writedata[1] = ($urandom_range(0, 3) != 0);
            end else if (r < 14) begin
                chipselect = 1'b1; write_n = 1'b0; address = 3'd0;
            end else if (r < 15) begin
                chipselect = 1'b1; write_n = 1'b0; address = 3'd4;
            end else if (r < 16) begin
                chipselect = 1'b1; write_n = 1'b0; address = 3'd5;
            end else if (r < 18) begin
                chipselect = 1'b1;
            end
            eA = expRead(0, address);
            eB = expRead(1, address);
            haveExp = 1'b1;
            @(negedge clk);
        end
        chipselect = 1'b0;
        write_n = 1'b1;
        tick_in = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        tick_in = 1'b0;
        chipselect = 1'b0;
        write_n = 1'b1;
        address = 3'd0;
        writedata = 16'd0;
        @(negedge clk);
        test_reset();
        test_single_tick();
        test_overrun();
        test_back_to_back();
        test_saturation();
        test_ovr_saturation();
        test_mon_disable();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/tick_latency_monitor.md
Name: tick_latency_monitor

Overview:
- Sits directly downstream of the periodic interval timer and consumes its level `irq` output as `tick_in`.
- Detects each new tick and re-presents it to the CPU as its own interrupt.
- Measures service latency from tick to software acknowledge, in clock cycles.
- Counts overruns, i.e. ticks that arrive while the previous tick is still unacknowledged.
- The CPU accesses it through a 16-bit Avalon-MM slave with registered read data, on the same bus as the timer.

Parameters:
- LAT_W, 16: width of the latency counter and latency registers; range 2..16. Latency registers are zero-extended to 16 bits on read.
- OVR_W, 16: width of the overrun counter; range 1..16.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- tick_in  in  1  timer interrupt level; rising edge = one tick.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- address  in  3  register word address.
- writedata  in  16  write data.
- readdata  out  16  registered read data.
- irq  out  1  interrupt to CPU.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset: all registers clear to 0, including readdata, irq, tick_d, pending, overrun, counters and CONTROL.
- Edge detect:
  - tick_d <= tick_in every cycle, regardless of enables.
  - edge = tick_in & ~tick_d & mon_en.
  - An edge in cycle N is visible as pending = 1 and lat = 0 in cycle N+1.
- Latency counter lat:
  - Cleared to 0 on an edge.
  - Increments by 1 every cycle while pending = 1.
  - Saturates at 2^LAT_W-1; it never wraps.
  - Acknowledge: an ACK write in cycle M while pending = 1 loads last_lat <= lat (value at M), and pending = 0 at M+1. Ack at cycle N+1+k therefore captures k.
- Max tracking: if the captured value is greater than max_lat, max_lat <= captured value (see Optional Feature).
- Overrun: edge while pending = 1 with no ACK in the same cycle:
  - ovr_cnt increments, saturating at 2^OVR_W-1.
  - overrun sticky bit is set.
  - pending stays 1.
  - lat is NOT restarted, so latency is measured from the oldest unacked tick.
- Simultaneous edge and ACK in the same cycle:
  - The ACK captures the old lat.
  - The edge then sets pending = 1 and lat = 0.
  - No overrun is counted.
- ACK with pending = 0: ignored. last_lat, max_lat and the counters are unchanged.
- tick_cnt increments on every edge and wraps modulo 2^16.
- irq = pending & irq_en. It is combinational from registers and glitch-free.
- mon_en = 0:
  - Edges are ignored.
  - An already-pending tick still counts latency and can still be acknowledged.
- Register map (write = chipselect & ~write_n):
  - 0 STATUS
    - Read: {14'b0, overrun, pending}.
    - Write with writedata[1] = 1 clears overrun. Other bits are ignored.
  - 1 CONTROL
    - Read/write bits [1:0]: bit0 irq_en, bit1 mon_en.
  - 2 ACK
    - Any write acknowledges.
    - Reads return 0.
  - 3 LAST_LAT: read-only.
  - 4 MAX_LAT
    - Read returns max_lat.
    - Any write clears it to 0. A clear in the same cycle as a capture takes the captured value.
  - 5 OVR_CNT
    - Read returns the overrun count.
    - Any write clears it to 0.
  - 6 TICK_CNT: read-only.
  - 7 reserved: reads return 0.
- Read timing:
  - readdata <= mux(address) every cycle.
  - Data for the address presented in cycle N is valid in cycle N+1, regardless of chipselect.
  - Reads have no side effects.
- Reset mid-operation: pending, lat and the counters clear immediately, irq drops the next cycle, and any in-flight ACK is lost.

Optional Feature:
- Macro: TICK_LATENCY_MAX_EN.
- Defined: max_lat is implemented as specified above.
- Undefined:
  - max_lat logic is removed.
  - Address 4 reads 0 and writes to it are ignored.
  - All other behaviour is identical.

Test Plan:
- Reset and read all 8 addresses -> every readdata = 0x0000, irq = 0.
- CONTROL = 0x3; pulse tick_in high at cycle 10; ACK write at cycle 21 -> irq high cycles 11–21, low at 22; LAST_LAT = 10; MAX_LAT = 10; TICK_CNT = 1.
- Two ticks 50 cycles apart, no ACK -> OVR_CNT = 1, STATUS = 0x3; ACK 5 cycles after the 2nd tick -> LAST_LAT = 54; write STATUS 0x2 -> STATUS = 0x0.
- Drive the tick edge and the ACK write in the same cycle while pending -> OVR_CNT unchanged, pending stays 1, next ACK 3 cycles later captures 2.
- LAT_W = 4, ACK 40 cycles after the tick -> LAST_LAT = 15 (saturated); ACK while not pending -> LAST_LAT stays 15.
- mon_en = 0, toggle tick_in 5 times -> TICK_CNT = 0, irq = 0; assert reset while pending -> irq = 0 the next cycle and all registers read 0.
